// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: time-multiplexed driver for an 8-digit common-anode
// seven-segment display. It snapshots the digit codes, enables and decimal
// points once per frame so a frame never tears. It scans one digit per
// DIGIT_PERIOD-cycle slot and keeps all anodes off for the first
// BLANK_CYCLES of each slot to suppress ghosting.
//
// Optional build macro SEVENSEG_LEADING_ZERO_BLANK_EN: blanks enabled zero
// digits that lie above the highest enabled nonzero digit (digit 0 is kept).
module sevenseg_scan_mux #(
  parameter int unsigned DIGIT_PERIOD = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] digits_in,
  input  logic [7:0]  dig_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an_n,
  output logic [7:0]  seg_n,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  // Code used to force a digit dark; any code from 19 to 31 decodes to blank.
  localparam logic [4:0] CODE_BLANK = 5'd31;

  // Active-low {a..g} pattern for one 5-bit display code.
  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'b0000001;
      5'd1:    decode = 7'b1001111;
      5'd2:    decode = 7'b0010010;
      5'd3:    decode = 7'b0000110;
      5'd4:    decode = 7'b1001100;
      5'd5:    decode = 7'b0100100;
      5'd6:    decode = 7'b0100000;
      5'd7:    decode = 7'b0001111;
      5'd8:    decode = 7'b0000000;
      5'd9:    decode = 7'b0000100;
      5'd10:   decode = 7'b0001000;
      5'd11:   decode = 7'b1100000;
      5'd12:   decode = 7'b0110001;
      5'd13:   decode = 7'b1000010;
      5'd14:   decode = 7'b0110000;
      5'd15:   decode = 7'b0111000;
      5'd16:   decode = 7'b1111110;
      5'd17:   decode = 7'b1110111;
      5'd18:   decode = 7'b1100010;
      default: decode = 7'b1111111;
    endcase
  endfunction

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // Walk from the leftmost digit down; enabled zeros seen before the first
  // enabled nonzero code are leading zeros and get replaced by a blank code.
  function automatic logic [7:0][4:0] suppress_leading_zeros(
    input logic [7:0][4:0] codes,
    input logic [7:0]      en
  );
    logic seen_nonzero;
    // NOTE: blocking assignments here (and in always_comb) model ordered
    // combinational evaluation; only flops use non-blocking assignments.
    seen_nonzero = 1'b0;
    suppress_leading_zeros = codes;
    for (int k = 7; k >= 1; k--) begin
      if (en[k] && (codes[k] != 5'd0)) begin
        seen_nonzero = 1'b1;
      end else if (en[k] && !seen_nonzero) begin
        suppress_leading_zeros[k] = CODE_BLANK;
      end
    end
  endfunction
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             load_pending_q, load_pending_d;
  logic [7:0][4:0]  code_snap_q, code_snap_d;
  logic [7:0]       en_snap_q, en_snap_d;
  logic [7:0]       dp_snap_q, dp_snap_d;
  logic [7:0]       an_n_q, an_n_d;
  logic [7:0]       seg_n_q, seg_n_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_wrap;
  logic             capture;
  logic [7:0][4:0]  capture_codes;

  // Next-state logic: prescaler, digit index, frame snapshot and outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    load_pending_d = load_pending_q;
    code_snap_d    = code_snap_q;
    en_snap_d      = en_snap_q;
    dp_snap_d      = dp_snap_q;
    an_n_d         = 8'hFF;
    seg_n_d        = 8'hFF;
    frame_tick_d   = 1'b0;

    slot_wrap = (cnt_q == CNT_LAST);
    if (slot_wrap) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    capture_codes = suppress_leading_zeros(digits_in, dig_en);
`else
    capture_codes = digits_in;
`endif

    // A frame ends on the last cycle of digit 7's slot; the very first
    // clock after reset also loads so the display never shows stale data.
    capture = load_pending_q || (slot_wrap && (idx_q == 3'd7));
    if (capture) begin
      code_snap_d    = capture_codes;
      en_snap_d      = dig_en;
      dp_snap_d      = dp_in;
      load_pending_d = 1'b0;
    end
    frame_tick_d = capture;

    // Segments are always driven for the current digit; the anode alone
    // decides visibility, and stays off during the slot's dead time.
    if (en_snap_q[idx_q] && (cnt_q >= CNT_BLANK)) begin
      an_n_d[idx_q] = 1'b0;
    end
    seg_n_d = {~dp_snap_q[idx_q], decode(code_snap_q[idx_q])};
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      load_pending_q <= 1'b1;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset
      // like any other state to give a defined picture before the first load.
      code_snap_q    <= '0;
      en_snap_q      <= 8'h00;
      dp_snap_q      <= 8'h00;
      an_n_q         <= 8'hFF;
      seg_n_q        <= 8'hFF;
      frame_tick_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      load_pending_q <= load_pending_d;
      code_snap_q    <= code_snap_d;
      en_snap_q      <= en_snap_d;
      dp_snap_q      <= dp_snap_d;
      an_n_q         <= an_n_d;
      seg_n_q        <= seg_n_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_tick = frame_tick_q;

endmodule
